// File: rtl/input_bcd_entry_pkg.sv
// Shared definitions for the IN-instruction BCD entry block.
// - FSM state encodings (3-bit constants, kept as plain localparams so the
//   encodings line up with the legacy state values).
// - BCD geometry: digit count, largest legal digit, accumulator width.
// - bcd_all_valid(): true when every nibble of a 4-digit word is 0..9.
package input_bcd_entry_pkg;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_WAIT_PRESS   = 3'd1;
  localparam logic [2:0] ST_CONVERT      = 3'd2;
  localparam logic [2:0] ST_DONE         = 3'd3;
  localparam logic [2:0] ST_WAIT_RELEASE = 3'd4;

  localparam int unsigned BCD_DIGITS    = 4;
  localparam int unsigned BCD_MAX_DIGIT = 9;
  localparam int unsigned BCD_W         = 4 * BCD_DIGITS;
  // 9999 = 0x270F fits in 14 bits.
  localparam int unsigned ACC_W         = 14;

  function automatic logic bcd_all_valid(input logic [BCD_W-1:0] value);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (value[4*i +: 4] > 4'(BCD_MAX_DIGIT)) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/input_bcd_entry_key_debounce.sv
// Enter-key conditioning: 2-flop synchronizer, debounce counter, stable level
// and a one-cycle press pulse.
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        synchronous, active-low reset
//   i_key_n        raw asynchronous key, active-low (0 = pressed)
//   o_press_pulse  one-cycle pulse on the stable released->pressed transition
//   o_released     stable (debounced) key level, 1 = released
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_key_n,
  output logic o_press_pulse,
  output logic o_released
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_stable) begin
        // The synced level must disagree for DEBOUNCE_CYCLES consecutive
        // cycles before it is accepted; any agreeing cycle restarts the count.
        if (r_cnt == CNT_LAST) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
          r_press  <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press_pulse = r_press;
  assign o_released    = r_stable;

endmodule

// File: rtl/input_bcd_entry.sv
// Front end for the IN instruction: while the core requests input, waits for
// an enter press, checks the four BCD digits on the switches, converts them to
// binary (4 multiply-accumulate cycles) and returns the value via req/valid.
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-low reset
//   in_req       core wants a value; held until data_valid has been seen
//   switches     four BCD digits, [15:12] thousands ... [3:0] units
//   key_n        enter button, asynchronous, active-low
//   data_out     converted binary value, zero-extended to DATA_W
//   data_valid   data_out is valid for the current request
//   waiting      block is waiting for the enter press (LED)
//   digit_error  last press rejected because a digit was above 9
module input_bcd_entry
  import input_bcd_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DATA_W          = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_req,
  input  logic [15:0]       switches,
  input  logic              key_n,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              waiting,
  output logic              digit_error
);

  logic [2:0]        r_state;
  logic [BCD_W-1:0]  r_shift;
  logic [ACC_W-1:0]  r_acc;
  logic [1:0]        r_digit_cnt;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_valid;
  logic              r_digit_error;

  logic              w_press_pulse;
  logic              w_released;
  logic [ACC_W-1:0]  w_acc_next;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_key_n       (key_n),
    .o_press_pulse (w_press_pulse),
    .o_released    (w_released)
  );

  // acc*10 + next digit, most significant digit first.
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + ACC_W'(r_shift[BCD_W-1 -: 4]);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_acc         <= '0;
      r_digit_cnt   <= '0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_digit_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_req) begin
            r_state       <= ST_WAIT_PRESS;
            r_digit_error <= 1'b0;
            r_data_valid  <= 1'b0;
          end
        end
        ST_WAIT_PRESS: begin
          if (!in_req) begin
            r_state <= ST_IDLE;
          end else if (w_press_pulse) begin
            if (bcd_all_valid(switches)) begin
              r_shift       <= switches;
              r_acc         <= '0;
              r_digit_cnt   <= '0;
              r_digit_error <= 1'b0;
              r_state       <= ST_CONVERT;
            end else begin
              r_digit_error <= 1'b1;
            end
          end
        end
        ST_CONVERT: begin
          r_acc       <= w_acc_next;
          r_shift     <= r_shift << 4;
          r_digit_cnt <= r_digit_cnt + 1'b1;
          if (r_digit_cnt == 2'(BCD_DIGITS - 1)) begin
            r_data_out   <= DATA_W'(w_acc_next);
            r_data_valid <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!in_req) begin
            r_data_valid <= 1'b0;
            r_state      <= ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          // A key still held from the previous IN must be released first.
          if (w_released) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign waiting     = (r_state == ST_WAIT_PRESS);
  assign digit_error = r_digit_error;

endmodule

// File: tb/tb_input_bcd_entry.sv
// Self-checking bench for input_bcd_entry: directed scenarios plus random
// stimulus, every cycle compared against a behavioural model of the entry
// protocol (digit value computed arithmetically, debounce as a run length).
module tb_input_bcd_entry;

  localparam int DEB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_req = 1'b0;
  logic [15:0] switches = '0;
  logic        key_n = 1'b1;
  logic [31:0] data_out;
  logic        data_valid;
  logic        waiting;
  logic        digit_error;

  input_bcd_entry #(
    .DEBOUNCE_CYCLES(DEB),
    .DATA_W(32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_req      (in_req),
    .switches    (switches),
    .key_n       (key_n),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .waiting     (waiting),
    .digit_error (digit_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_dv_rise = 0;
  bit dv_prev  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_WAIT, M_CONV, M_DONE, M_REL} mstate_t;

  bit          m_key_d1 = 1'b1;   // key_n seen one edge ago
  bit          m_key_d2 = 1'b1;   // key_n seen two edges ago (synced view)
  bit          m_stable = 1'b1;
  int          m_run    = 0;
  bit          m_press  = 1'b0;
  mstate_t     m_state  = M_IDLE;
  int          m_timer  = 0;
  logic [15:0] m_sw     = '0;
  logic [31:0] m_dout   = '0;
  bit          m_dv     = 1'b0;
  bit          m_err    = 1'b0;

  function automatic bit all_bcd(input logic [15:0] s);
    for (int i = 0; i < 4; i++) if (s[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd_value(input logic [15:0] s);
    return int'(s[15:12]) * 1000 + int'(s[11:8]) * 100 + int'(s[7:4]) * 10 + int'(s[3:0]);
  endfunction

  task automatic model_step();
    if (!reset) begin
      m_key_d1 = 1; m_key_d2 = 1; m_stable = 1; m_run = 0; m_press = 0;
      m_state = M_IDLE; m_timer = 0; m_dout = 0; m_dv = 0; m_err = 0;
      return;
    end
    case (m_state)
      M_IDLE: if (in_req) begin m_state = M_WAIT; m_err = 0; m_dv = 0; end
      M_WAIT: begin
        if (!in_req) m_state = M_IDLE;
        else if (m_press) begin
          if (all_bcd(switches)) begin
            m_sw = switches; m_timer = 4; m_err = 0; m_state = M_CONV;
          end else m_err = 1;
        end
      end
      M_CONV: begin
        m_timer--;
        if (m_timer == 0) begin
          m_dout = 32'(bcd_value(m_sw)); m_dv = 1; m_state = M_DONE;
        end
      end
      M_DONE: if (!in_req) begin m_dv = 0; m_state = M_REL; end
      M_REL:  if (m_stable) m_state = M_IDLE;
      default: m_state = M_IDLE;
    endcase
    m_press = 0;
    if (m_key_d2 != m_stable) begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = m_key_d2; m_run = 0; m_press = !m_stable;
      end
    end else m_run = 0;
    m_key_d2 = m_key_d1;
    m_key_d1 = key_n;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    chk("cyc_data_out", data_out, m_dout);
    chk("cyc_data_valid", 32'(data_valid), 32'(m_dv));
    chk("cyc_waiting", 32'(waiting), 32'(m_state == M_WAIT));
    chk("cyc_digit_error", 32'(digit_error), 32'(m_err));
    if (data_valid && !dv_prev) n_dv_rise++;
    dv_prev = data_valid;
  endtask

  // Full IN transaction from IDLE with the key released.
  task automatic do_conversion(input logic [15:0] sw, input logic [31:0] exp, input string tag);
    int fall_cyc;
    int cyc;
    bit got;
    bit prev_wait;
    fall_cyc = -1; cyc = 0; got = 0;
    switches = sw; in_req = 1;
    tick(); tick();
    key_n = 0;
    prev_wait = waiting;
    for (int i = 0; i < 40 && !got; i++) begin
      tick(); cyc++;
      if (prev_wait && !waiting && fall_cyc < 0) fall_cyc = cyc;
      if (data_valid) got = 1;
      prev_wait = waiting;
    end
    chk({tag, "_valid"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc - fall_cyc), 32'd4);
    chk({tag, "_data"}, data_out, exp);
    tick();
    chk({tag, "_hold"}, 32'(data_valid), 32'd1);
    in_req = 0; key_n = 1;
    tick();
    chk({tag, "_drop"}, 32'(data_valid), 32'd0);
    chk({tag, "_kept"}, data_out, exp);
    repeat (10) tick();
  endtask

  initial begin
    int rises;
    bit prev_wait;
    bit seen;

    // Reset state
    reset = 0;
    tick(); tick();
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_waiting", 32'(waiting), 32'd0);
    chk("rst_err", 32'(digit_error), 32'd0);
    reset = 1;
    tick();

    // Basic and boundary conversions
    do_conversion(16'h1234, 32'h0000_04D2, "basic");
    do_conversion(16'h9999, 32'h0000_270F, "max");
    do_conversion(16'h0000, 32'h0000_0000, "zero");

    // Invalid digit then a corrected entry
    in_req = 1; switches = 16'h12A4;
    tick(); tick();
    key_n = 0; repeat (10) tick();
    chk("bad_err", 32'(digit_error), 32'd1);
    chk("bad_waiting", 32'(waiting), 32'd1);
    chk("bad_valid", 32'(data_valid), 32'd0);
    key_n = 1; repeat (8) tick();
    do_conversion(16'h0042, 32'd42, "fixed");
    chk("fixed_err", 32'(digit_error), 32'd0);

    // Short glitch is ignored
    in_req = 1; switches = 16'h0011;
    tick(); tick();
    key_n = 0; tick(); tick();
    key_n = 1; repeat (10) tick();
    chk("glitch_waiting", 32'(waiting), 32'd1);
    chk("glitch_valid", 32'(data_valid), 32'd0);

    // Bouncing then steady low: one conversion
    rises = n_dv_rise;
    for (int i = 0; i < 5; i++) begin key_n = i[0]; tick(); end
    key_n = 0;
    repeat (30) tick();
    chk("bounce_count", 32'(n_dv_rise - rises), 32'd1);
    chk("bounce_data", data_out, 32'd11);

    // Key held across the next request: no second conversion
    in_req = 0; repeat (3) tick();
    in_req = 1; rises = n_dv_rise;
    repeat (20) tick();
    chk("held_count", 32'(n_dv_rise - rises), 32'd0);
    chk("held_waiting", 32'(waiting), 32'd0);
    key_n = 1; repeat (10) tick();
    chk("released_waiting", 32'(waiting), 32'd1);
    in_req = 0; tick();
    do_conversion(16'h0358, 32'd358, "after_rel");

    // Abort in WAIT_PRESS, then a press with no request
    in_req = 1; tick(); tick();
    chk("abort_pre", 32'(waiting), 32'd1);
    in_req = 0; tick();
    chk("abort_waiting", 32'(waiting), 32'd0);
    rises = n_dv_rise;
    key_n = 0; repeat (10) tick();
    key_n = 1; repeat (10) tick();
    chk("ignored_count", 32'(n_dv_rise - rises), 32'd0);
    chk("ignored_waiting", 32'(waiting), 32'd0);

    // Reset during the second CONVERT cycle
    in_req = 1; switches = 16'h5678;
    tick(); tick();
    key_n = 0; prev_wait = waiting; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (prev_wait && !waiting) seen = 1;
      prev_wait = waiting;
    end
    chk("midrst_reached", 32'(seen), 32'd1);
    tick();
    reset = 0; key_n = 1;
    tick();
    chk("midrst_data", data_out, 32'd0);
    chk("midrst_valid", 32'(data_valid), 32'd0);
    chk("midrst_waiting", 32'(waiting), 32'd0);
    chk("midrst_err", 32'(digit_error), 32'd0);
    reset = 1; in_req = 0;
    repeat (8) tick();
    do_conversion(16'h0007, 32'd7, "post_rst");

    // Random traffic against the model
    for (int it = 0; it < 250; it++) begin
      int hold;
      in_req = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 1) == 1) begin
        switches = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                    4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end else begin
        switches = 16'($urandom);
      end
      key_n = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 49) != 0);
      hold = $urandom_range(1, 8);
      repeat (hold) tick();
      reset = 1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/input_bcd_entry.md
Name: input_bcd_entry

Overview:
- User-input front end for the processor's IN instruction; the input-side counterpart of the binary-to-BCD display path.
- While the core requests input, the block accepts four BCD digits from the board switches, confirmed by a debounced push-button.
- It converts the digits to binary and returns the value to the datapath through a req/valid handshake.
- It sits between the board I/O (switches, key) and the register-file write mux.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz).
- DATA_W, 32, width of data_out.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_req  in  1  core is stalled on IN and wants a value; level, held until data_valid has been seen.
- switches  in  16  four BCD digits; [15:12] is the thousands digit, [3:0] is the units digit.
- key_n  in  1  enter button, asynchronous, active-low (0 = pressed).
- data_out  out  DATA_W  converted binary value, zero-extended.
- data_valid  out  1  data_out is valid for the current request.
- waiting  out  1  block is waiting for the user to press enter (drives an LED).
- digit_error  out  1  last press was rejected because a digit was greater than 9.

Behaviour:
- Reset (reset == 0 at a rising edge):
  - Outputs: data_out = 0, data_valid = 0, waiting = 0, digit_error = 0.
  - Internals: FSM = IDLE, synchronizer = 1, debounced key = released, debounce counter = 0.
  - Reset mid-conversion discards the partial result.
- Key path:
  - key_n passes through a 2-flop synchronizer.
  - The debounce counter increments while the synced value differs from the stable value and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable value flips and the counter clears.
  - press_pulse is a 1-cycle pulse on the stable released->pressed transition.
  - released is the stable level.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- FSM states: IDLE, WAIT_PRESS, CONVERT, DONE, WAIT_RELEASE.
- IDLE:
  - waiting = 0.
  - If in_req = 1, go to WAIT_PRESS; clear digit_error and data_valid.
- WAIT_PRESS:
  - waiting = 1.
  - If in_req = 0, go to IDLE (abort).
  - On press_pulse with every switches nibble <= 9: latch switches into a shift register, acc = 0, digit count = 0, digit_error = 0, go to CONVERT.
  - On press_pulse with any nibble > 9: digit_error = 1 and stay. Release-before-next-press is inherent in press_pulse.
- CONVERT:
  - waiting = 0.
  - Exactly 4 cycles. Each cycle: acc = (acc<<3) + (acc<<1) + shift[15:12], then shift <<= 4.
  - After the 4th cycle, data_out = acc, data_valid = 1, go to DONE.
  - acc is 14 bits wide (maximum 9999 = 0x270F); data_out[DATA_W-1:14] = 0.
  - in_req dropping during CONVERT does not abort; DONE resolves it.
- Latency: data_valid rises on the 4th rising edge after the edge that leaves WAIT_PRESS.
- DONE:
  - data_valid and data_out are held.
  - When in_req = 0, data_valid = 0 and go to WAIT_RELEASE.
  - data_out keeps its last value until the next conversion.
- WAIT_RELEASE:
  - Go to IDLE when the debounced key is released.
  - This prevents one long press from satisfying two consecutive IN instructions.
- Switch changes outside WAIT_PRESS have no effect. Switches are sampled only on the press_pulse cycle.

Decomposition:
- Shared package:
  - FSM state encoding (3-bit localparams).
  - BCD_DIGITS = 4.
  - BCD_MAX_DIGIT = 9.
- Sub-module: key_debounce (synchronizer, counter, stable level, press_pulse), parameterised by DEBOUNCE_CYCLES.
- The FSM and multiply-accumulate stay in input_bcd_entry.

Test Plan (bench uses DEBOUNCE_CYCLES = 4):
- Basic conversion: in_req = 1, switches = 16'h1234, clean press -> waiting drops, data_valid = 1 exactly 4 cycles after leaving WAIT_PRESS, data_out = 32'h000004D2. Hold until in_req = 0, then data_valid = 0 next cycle.
- Boundaries: switches = 16'h9999 -> data_out = 32'h0000270F; switches = 16'h0000 -> data_out = 0 with data_valid = 1.
- Invalid digit: switches = 16'h12A4 with a press -> digit_error = 1, no data_valid, waiting stays 1. Then switches = 16'h0042 with a new press -> digit_error = 0, data_out = 32'd42.
- Debounce: key_n low for 2 cycles -> no state change. Bouncing 1-cycle pulses then a steady low -> exactly one conversion. Holding the key through a second in_req -> no second conversion until release plus a new press.
- Abort: in_req dropped in WAIT_PRESS -> IDLE, waiting = 0, no data_valid. A later press with in_req = 0 -> ignored.
- Reset mid-operation: reset = 0 during the 2nd CONVERT cycle -> next cycle all outputs 0 and FSM in IDLE. A new request then converts 16'h0007 -> 32'd7.
